if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter IMEM_TIMEOUT, default 0, extra cycles before a repeated imem_req is re-asserted; 0 disables the timeout.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst_b  input  1  reset, asynchronous and active-low.
REQ-005 stall  input  1  decode cannot accept; hold the current instruction.
REQ-006 redirect_valid  input  1  taken branch/jump/jr resolved downstream.
REQ-007 redirect_pc  input  32  target PC for redirect.
REQ-008 halted  input  1  decode reports a syscall/halt on the current instruction.
REQ-009 imem_req  output  1  memory read request.
REQ-010 imem_addr  output  32  word-aligned request address.
REQ-011 imem_ack  input  1  read data valid this cycle.
REQ-012 imem_rdata  input  32  instruction word.
REQ-013 inst  output  32  instruction presented to decode.
REQ-014 inst_pc  output  32  PC of inst.
REQ-015 pc_plus4  output  32  inst_pc + 4, used for link-register writes.
REQ-016 inst_valid  output  1  inst is a real instruction, not a bubble.
REQ-017 perf_fetch_cnt / perf_bubble_cnt  output  32 each  performance counters.

Function
REQ-018 State machine states:
- FETCH: issue a request.
- WAIT: request outstanding.
- DROP: outstanding response must be discarded.
- HALT: terminal.
REQ-019 FETCH asserts imem_req with imem_addr = fetch_pc when the 2-entry buffer has a free slot, counting the outstanding entry; then go to WAIT.
REQ-020 WAIT: imem_req stays high and imem_addr stays stable until imem_ack.
- On ack, push {imem_rdata, fetch_pc} into the buffer and set fetch_pc += 4, with 32-bit wrap.
- After the ack, return to FETCH.
REQ-021 redirect_valid has priority over every other event.
- Flush the buffer and clear inst_valid the next cycle.
- Set fetch_pc = {redirect_pc[31:2], 2'b00}.
- From WAIT without a same-cycle ack, go to DROP.
- Otherwise go to FETCH.
REQ-022 DROP: the next imem_ack is discarded, then go to FETCH; imem_req is low while in DROP.
REQ-023 Output register: when stall=0, load the buffer head into inst/inst_pc and pop it.
- If the buffer is empty, inst = 32'h0 (NOP) and inst_valid = 0.
REQ-024 When stall=1, inst, inst_pc and inst_valid hold; buffer pushes continue.
REQ-025 When stall=1 and redirect_valid=1 in the same cycle, redirect wins and flushes the output register.
REQ-026 When halted=1 and inst_valid=1, go to HALT.
- In HALT: imem_req=0, the buffer is flushed, and inst/inst_pc hold.
- HALT is left only by reset.
REQ-027 The buffer never overflows; a push and a pop in the same cycle on a full buffer are legal.
REQ-028 pc_plus4 is combinational from inst_pc, with modulo-2^32 wrap.
REQ-029 Latency: with no stall and a 1-cycle ack, a fetched word reaches inst 2 cycles after imem_req; steady-state throughput is 1 instruction per cycle.

Reset
REQ-030 On rst_b low, the following values apply immediately:
- fetch_pc = RESET_PC; state = FETCH; buffer empty.
- inst = 0, inst_pc = RESET_PC, inst_valid = 0, imem_req = 0, counters = 0.
REQ-031 The first imem_req is raised in the first cycle after rst_b deasserts.
REQ-032 Reset mid-WAIT abandons the outstanding request; a late ack after reset is ignored via DROP-equivalent logic, i.e. ack is ignored while imem_req=0.

Configuration
REQ-033 Macro IF_PERF_COUNTERS_EN.
- Defined: perf_fetch_cnt increments on each accepted (pushed) word, and perf_bubble_cnt increments each cycle with inst_valid=0 and stall=0; both saturate at 32'hFFFF_FFFF.
- Undefined: both ports are tied to 0 and no counter flops exist.

Structure
REQ-034 Shared package mips_pkg holds:
- if_state_t enum {FETCH, WAIT, DROP, HALT};
- NOP_INST = 32'h0;
- buffer entry struct {inst, pc}.
REQ-035 One sub-module, if_inst_buffer: a 2-entry FIFO with push/pop/flush, full/empty outputs and a simultaneous push/pop rule.

Verification
REQ-036 Reset with RESET_PC=32'h0040_0000 and 1-cycle ack memory: imem_addr sequence is 0x400000, 0x400004, 0x400008; inst_valid goes high on cycle 2.
REQ-037 stall held 3 cycles: inst/inst_pc are unchanged; at most 2 further acks are accepted; no word is lost or duplicated after release.
REQ-038 redirect_valid with redirect_pc=0x00400103 during WAIT with ack 2 cycles later: the late word is dropped and the next imem_addr is 0x00400100.
REQ-039 Simultaneous stall=1 and redirect: inst_valid=0 next cycle and the buffer is empty.
REQ-040 halted=1 with inst_valid=1: imem_req stays low for 10 cycles and inst holds; a later rst_b pulse restarts at RESET_PC.
REQ-041 With IF_PERF_COUNTERS_EN, 5 fetches plus 2 empty unstalled cycles give perf_fetch_cnt=5 and perf_bubble_cnt=2; without the macro both read 0.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the instruction fetch stage
//
// Purpose : fetch FSM state encoding, NOP constant and the instruction buffer
//           entry layout used by if_stage and if_inst_buffer.
// Ports   : none (package).
package mips_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2,
    HALT  = 2'd3
  } if_state_t;

  localparam logic [31:0] NOP_INST = 32'h0;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } if_buf_entry_t;

endpackage

// File: rtl/if_inst_buffer.sv
// rtl/if_inst_buffer.sv - 2-entry instruction FIFO between imem and decode
//
// Purpose : holds fetched {inst, pc} words until decode takes them.
// Ports   : clk, rst_b     clock, async active-low reset
//           push/push_data write one entry (accepted when not full, or when
//                          a pop happens in the same cycle)
//           pop            remove head entry (ignored when empty)
//           flush          empty the FIFO; wins over push/pop
//           head           current head entry (valid when !empty)
//           full, empty    occupancy flags
module if_inst_buffer
  import mips_pkg::*;
(
  input  logic          clk,
  input  logic          rst_b,
  input  logic          push,
  input  if_buf_entry_t push_data,
  input  logic          pop,
  input  logic          flush,
  output if_buf_entry_t head,
  output logic          full,
  output logic          empty
);

  if_buf_entry_t mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_pop  = pop && !empty;
  // A full buffer may still take a word if the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Payload storage needs no reset: it is only read while count says valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with 2-entry prefetch buffer
//
// Purpose : issues word reads to instruction memory, buffers returned words
//           and presents one instruction per cycle to decode; handles stall,
//           redirect (branch/jump) and halt.
// Config  : IF_PERF_COUNTERS_EN enables the fetch/bubble counters; when
//           undefined both counter ports read 0 and no counter flops exist.
// Params  : RESET_PC      first fetch address after reset
//           IMEM_TIMEOUT  WAIT cycles without ack before the request is
//                         re-issued; 0 disables
// Ports   : clk, rst_b                  clock, async active-low reset
//           stall, halted               decode back-pressure / halt report
//           redirect_valid, redirect_pc redirect request and target
//           imem_req, imem_addr         memory read request
//           imem_ack, imem_rdata        memory response
//           inst, inst_pc, pc_plus4     instruction to decode and its PCs
//           inst_valid                  inst is real (not a bubble)
//           perf_fetch_cnt, perf_bubble_cnt  saturating counters
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned IMEM_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halted,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] pc_plus4,
  output logic        inst_valid,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
);

  localparam logic [31:0] TIMEOUT_CYC = 32'(IMEM_TIMEOUT);

  if_state_t     state, state_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic [31:0]   wait_cnt;
  logic          timeout_hit;
  logic          push, pop, flush;
  logic          halt_now;
  logic          outstanding;
  logic          buf_full, buf_empty;
  if_buf_entry_t buf_head;
  if_buf_entry_t push_data;
  logic          unused_lsbs;

  assign unused_lsbs = ^redirect_pc[1:0];

  // Gating with rst_b keeps the request low while reset is asserted even
  // though the reset state (FETCH, empty buffer) would otherwise request.
  assign imem_req  = rst_b && (((state == FETCH) && !buf_full) || (state == WAIT));
  assign imem_addr = fetch_pc;
  assign pc_plus4  = inst_pc + 32'd4;

  assign halt_now    = halted && inst_valid && (state != HALT);
  // A response is still owed either by a live request or by an earlier one
  // already marked for discard.
  assign outstanding = imem_req || (state == DROP);
  assign timeout_hit = (TIMEOUT_CYC != 32'd0) && (wait_cnt == TIMEOUT_CYC);

  assign push_data.inst = imem_rdata;
  assign push_data.pc   = fetch_pc;

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    push         = 1'b0;
    pop          = 1'b0;
    flush        = 1'b0;
    if (state == HALT) begin
      flush = 1'b1;
    end else if (redirect_valid) begin
      flush        = 1'b1;
      fetch_pc_nxt = {redirect_pc[31:2], 2'b00};
      state_nxt    = (outstanding && !imem_ack) ? DROP : FETCH;
    end else if (halt_now) begin
      flush     = 1'b1;
      state_nxt = HALT;
    end else begin
      pop = !stall && !buf_empty;
      case (state)
        FETCH: begin
          // With a same-cycle ack the word is taken here and FETCH repeats,
          // giving one request per cycle.
          if (imem_req) begin
            if (imem_ack) begin
              push         = 1'b1;
              fetch_pc_nxt = fetch_pc + 32'd4;
            end else begin
              state_nxt = WAIT;
            end
          end
        end
        WAIT: begin
          if (imem_ack) begin
            push         = 1'b1;
            fetch_pc_nxt = fetch_pc + 32'd4;
            state_nxt    = FETCH;
          end else if (timeout_hit) begin
            state_nxt = FETCH;
          end
        end
        DROP: begin
          if (imem_ack) state_nxt = FETCH;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      wait_cnt <= 32'd0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      wait_cnt <= ((state == WAIT) && (state_nxt == WAIT)) ? wait_cnt + 32'd1 : 32'd0;
    end
  end

  // Output register. HALT and the halting cycle freeze it so decode keeps
  // seeing the halting instruction.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      inst       <= NOP_INST;
      inst_pc    <= RESET_PC;
      inst_valid <= 1'b0;
    end else if (state != HALT) begin
      if (redirect_valid) begin
        inst       <= NOP_INST;
        inst_valid <= 1'b0;
      end else if (!halt_now && !stall) begin
        if (!buf_empty) begin
          inst       <= buf_head.inst;
          inst_pc    <= buf_head.pc;
          inst_valid <= 1'b1;
        end else begin
          inst       <= NOP_INST;
          inst_valid <= 1'b0;
        end
      end
    end
  end

  if_inst_buffer u_buf (
    .clk       (clk),
    .rst_b     (rst_b),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (flush),
    .head      (buf_head),
    .full      (buf_full),
    .empty     (buf_empty)
  );

`ifdef IF_PERF_COUNTERS_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      fetch_cnt  <= 32'd0;
      bubble_cnt <= 32'd0;
    end else begin
      if (push && (fetch_cnt != 32'hFFFF_FFFF))
        fetch_cnt <= fetch_cnt + 32'd1;
      if (!inst_valid && !stall && (bubble_cnt != 32'hFFFF_FFFF))
        bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt  = fetch_cnt;
  assign perf_bubble_cnt = bubble_cnt;
`else
  assign perf_fetch_cnt  = 32'd0;
  assign perf_bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

`ifdef IF_PERF_COUNTERS_EN
  localparam logic [31:0] EXP_FETCH5 = 32'd5;
  localparam logic [31:0] EXP_BUB2   = 32'd2;
`else
  localparam logic [31:0] EXP_FETCH5 = 32'd0;
  localparam logic [31:0] EXP_BUB2   = 32'd0;
`endif

  logic        clk;
  logic        rst_b;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc_plus4;
  logic        inst_valid;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;

  logic        mem_auto;
  logic        ack_manual;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_A5A5;
  endfunction

  // Auto mode answers every request in the same cycle; manual mode lets the
  // sequence place acks by hand.
  assign imem_ack   = mem_auto ? imem_req : ack_manual;
  assign imem_rdata = mem_word(imem_addr);

  if_stage #(.RESET_PC(RST_PC), .IMEM_TIMEOUT(0)) dut (
    .clk             (clk),
    .rst_b           (rst_b),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .halted          (halted),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .pc_plus4        (pc_plus4),
    .inst_valid      (inst_valid),
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_b = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    halted = 1'b0; mem_auto = 1'b1; ack_manual = 1'b0;

    @(negedge clk);
    chk("rst_req",    {31'b0, imem_req},   32'h0);
    chk("rst_inst",   inst,                32'h0);
    chk("rst_pc",     inst_pc,             RST_PC);
    chk("rst_valid",  {31'b0, inst_valid}, 32'h0);
    chk("rst_pfetch", perf_fetch_cnt,      32'h0);
    chk("rst_pbub",   perf_bubble_cnt,     32'h0);

    @(negedge clk);
    rst_b = 1'b1;
    #1;
    chk("first_req",  {31'b0, imem_req}, 32'h1);
    chk("addr0",      imem_addr,         32'h0040_0000);
    @(negedge clk);
    chk("addr1",      imem_addr,         32'h0040_0004);
    chk("valid_c1",   {31'b0, inst_valid}, 32'h0);
    @(negedge clk);
    chk("addr2",      imem_addr,         32'h0040_0008);
    chk("valid_c2",   {31'b0, inst_valid}, 32'h1);
    chk("pc_c2",      inst_pc,           32'h0040_0000);
    chk("inst_c2",    inst,              mem_word(32'h0040_0000));
    chk("plus4_c2",   pc_plus4,          32'h0040_0004);
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("pc_c5",      inst_pc,           32'h0040_000C);
    chk("perf_fetch", perf_fetch_cnt,    EXP_FETCH5);
    chk("perf_bub",   perf_bubble_cnt,   EXP_BUB2);

    // Stall for three cycles: output frozen, buffer fills and stops requesting.
    stall = 1'b1;
    @(negedge clk);
    chk("stall_pc1",  inst_pc,           32'h0040_000C);
    chk("stall_req1", {31'b0, imem_req}, 32'h0);
    @(negedge clk);
    chk("stall_pc2",  inst_pc,           32'h0040_000C);
    chk("stall_req2", {31'b0, imem_req}, 32'h0);
    @(negedge clk);
    chk("stall_pc3",  inst_pc,           32'h0040_000C);
    chk("stall_inst", inst,              mem_word(32'h0040_000C));
    stall = 1'b0;
    @(negedge clk);
    chk("rel_pc0",    inst_pc,           32'h0040_0010);
    chk("rel_inst0",  inst,              mem_word(32'h0040_0010));
    chk("rel_addr",   imem_addr,         32'h0040_0018);
    @(negedge clk);
    chk("rel_pc1",    inst_pc,           32'h0040_0014);
    @(negedge clk);
    chk("rel_pc2",    inst_pc,           32'h0040_0018);
    @(negedge clk);
    chk("rel_pc3",    inst_pc,           32'h0040_001C);

    // Redirect while a request waits; its ack arrives two cycles later.
    mem_auto = 1'b0;
    @(negedge clk);
    chk("wait_req",   {31'b0, imem_req}, 32'h1);
    chk("wait_addr",  imem_addr,         32'h0040_0024);
    chk("wait_pc",    inst_pc,           32'h0040_0020);
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0103;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("redir_valid", {31'b0, inst_valid}, 32'h0);
    chk("redir_inst",  inst,               32'h0);
    chk("drop_req0",   {31'b0, imem_req},  32'h0);
    @(negedge clk);
    chk("drop_req1",   {31'b0, imem_req},  32'h0);
    ack_manual = 1'b1;
    @(negedge clk);
    ack_manual = 1'b0;
    chk("post_drop_req",  {31'b0, imem_req}, 32'h1);
    chk("post_drop_addr", imem_addr,         32'h0040_0100);
    mem_auto = 1'b1;
    @(negedge clk);
    chk("redir_bubble",   {31'b0, inst_valid}, 32'h0);
    @(negedge clk);
    chk("redir_pc",       inst_pc,           32'h0040_0100);
    chk("redir_inst1",    inst,              mem_word(32'h0040_0100));
    chk("redir_valid1",   {31'b0, inst_valid}, 32'h1);
    @(negedge clk);
    chk("redir_pc2",      inst_pc,           32'h0040_0104);

    // Stall and redirect together: redirect flushes output and buffer.
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0040_0200;
    @(negedge clk);
    stall = 1'b0; redirect_valid = 1'b0;
    chk("sr_valid",   {31'b0, inst_valid}, 32'h0);
    chk("sr_inst",    inst,               32'h0);
    chk("sr_addr",    imem_addr,          32'h0040_0200);
    @(negedge clk);
    chk("sr_empty",   {31'b0, inst_valid}, 32'h0);
    @(negedge clk);
    chk("sr_pc",      inst_pc,            32'h0040_0200);
    chk("sr_valid1",  {31'b0, inst_valid}, 32'h1);

    // Address wrap at the top of the 32-bit space, misaligned target.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("wrap_addr0", imem_addr,          32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_addr1", imem_addr,          32'h0000_0000);
    @(negedge clk);
    chk("wrap_pc",    inst_pc,            32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4,           32'h0000_0000);
    chk("wrap_inst",  inst,               32'h5A5A_5A59);
    @(negedge clk);
    chk("wrap_pc1",   inst_pc,            32'h0000_0000);
    chk("wrap_p4_1",  pc_plus4,           32'h0000_0004);

    // Halt: requests stop, output holds, redirect is ignored.
    halted = 1'b1;
    @(negedge clk);
    halted = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("halt_req",  {31'b0, imem_req}, 32'h0);
      chk("halt_pc",   inst_pc,           32'h0000_0000);
      chk("halt_inst", inst,              32'hA5A5_A5A5);
      redirect_valid = (i == 3);
      redirect_pc    = 32'h0040_0300;
      @(negedge clk);
    end
    redirect_valid = 1'b0;

    rst_b = 1'b0;
    #1;
    chk("rst2_inst",  inst,               32'h0);
    chk("rst2_pc",    inst_pc,            RST_PC);
    chk("rst2_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst2_req",   {31'b0, imem_req},  32'h0);
    @(negedge clk);
    rst_b = 1'b1;
    #1;
    chk("rst2_req1",  {31'b0, imem_req},  32'h1);
    chk("rst2_addr0", imem_addr,          32'h0040_0000);
    @(negedge clk);
    chk("rst2_addr1", imem_addr,          32'h0040_0004);
    @(negedge clk);
    chk("rst2_ipc",   inst_pc,            32'h0040_0000);
    chk("rst2_iv",    {31'b0, inst_valid}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
